// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side sequencer for a single-cycle MIPS core.
// Holds the PC, selects the next PC from decoded flow-control signals, and runs
// a RUN/HALT machine that stops the core on an exit syscall. Also keeps
// saturating performance counters for the board display.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   stall              hold PC this cycle; only cycle_cnt keeps counting
//   go                 leave HALT, resuming at pc+4
//   beq..syscall       decoded flow-control flags (expected one-hot)
//   imm16, target26    instruction immediate fields
//   rs_data, rt_data   register-file read ports
//   v0_data            current $v0, compared against HALT_CODE on syscall
//   pc, pc_plus4       fetch address and its sequential successor / jal link
//   halted             1 while in HALT
//   cycle_cnt, jump_cnt, branch_cnt, taken_cnt   performance counters
module pc_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_CODE = 32'd10,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             go,
   input  logic             beq,
   input  logic             bne,
   input  logic             blez,
   input  logic             jmp,
   input  logic             jal,
   input  logic             jr,
   input  logic             syscall,
   input  logic [15:0]      imm16,
   input  logic [25:0]      target26,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      rt_data,
   input  logic [31:0]      v0_data,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] jump_cnt,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   localparam logic StRun  = 1'b0;
   localparam logic StHalt = 1'b1;

   logic             state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] jmp_q, jmp_d;
   logic [CNT_W-1:0] br_q, br_d;
   logic [CNT_W-1:0] tk_q, tk_d;

   logic        is_jump;
   logic        is_branch;
   logic        br_taken;
   logic        halt_req;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   assign pc_plus4  = pc_q + 32'd4;
   assign is_jump   = jr | jmp | jal;
   assign is_branch = beq | bne | blez;
   // blez: signed rs <= 0 is "sign bit set or exactly zero"
   assign br_taken  = (beq  & (rs_data == rt_data)) |
                      (bne  & (rs_data != rt_data)) |
                      (blez & (rs_data[31] | (rs_data == 32'd0)));
   assign halt_req  = syscall & (v0_data == HALT_CODE);
   assign br_tgt    = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
   assign j_tgt     = {pc_plus4[31:28], target26, 2'b00};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cyc_d   = cyc_q;
      jmp_d   = jmp_q;
      br_d    = br_q;
      tk_d    = tk_q;
      if (state_q == StRun) begin
         cyc_d = sat_inc(cyc_q);
         if (!stall) begin
            if (halt_req) begin
               state_d = StHalt;
            end else if (jr) begin
               pc_d = rs_data;
            end else if (jmp | jal) begin
               pc_d = j_tgt;
            end else if (br_taken) begin
               pc_d = br_tgt;
            end else begin
               pc_d = pc_plus4;
            end
            if (is_jump) begin
               jmp_d = sat_inc(jmp_q);
            end
            if (is_branch) begin
               br_d = sat_inc(br_q);
            end
            if (br_taken) begin
               tk_d = sat_inc(tk_q);
            end
         end
      end else if (go) begin
         // Resume past the halting syscall; this edge is not counted.
         state_d = StRun;
         pc_d    = pc_plus4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
         pc_q    <= RESET_PC;
         cyc_q   <= '0;
         jmp_q   <= '0;
         br_q    <= '0;
         tk_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cyc_q   <= cyc_d;
         jmp_q   <= jmp_d;
         br_q    <= br_d;
         tk_q    <= tk_d;
      end
   end

   assign pc         = pc_q;
   assign halted     = (state_q == StHalt);
   assign cycle_cnt  = cyc_q;
   assign jump_cnt   = jmp_q;
   assign branch_cnt = br_q;
   assign taken_cnt  = tk_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed steps followed by random cycles, all checked
// against a behavioural model. A second instance with 3-bit counters checks
// counter saturation using the same stimulus.
module tb_pc_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic stall, go, beq, bne, blez, jmp, jal, jr, syscall;
   logic [15:0] imm16;
   logic [25:0] target26;
   logic [31:0] rs_data, rt_data, v0_data;

   logic [31:0] pc, pc_plus4;
   logic        halted;
   logic [31:0] cycle_cnt, jump_cnt, branch_cnt, taken_cnt;

   logic [31:0] pc_s, pc_plus4_s;
   logic        halted_s;
   logic [2:0]  cycle_cnt_s, jump_cnt_s, branch_cnt_s, taken_cnt_s;

   int total = 0;
   int bad   = 0;

   // model state
   logic [31:0] m_pc;
   bit          m_halt;
   longint      m_cyc, m_jmp, m_br, m_tk;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .stall(stall), .go(go),
      .beq(beq), .bne(bne), .blez(blez), .jmp(jmp), .jal(jal), .jr(jr),
      .syscall(syscall), .imm16(imm16), .target26(target26),
      .rs_data(rs_data), .rt_data(rt_data), .v0_data(v0_data),
      .pc(pc), .pc_plus4(pc_plus4), .halted(halted),
      .cycle_cnt(cycle_cnt), .jump_cnt(jump_cnt),
      .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   pc_sequencer #(.CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .stall(stall), .go(go),
      .beq(beq), .bne(bne), .blez(blez), .jmp(jmp), .jal(jal), .jr(jr),
      .syscall(syscall), .imm16(imm16), .target26(target26),
      .rs_data(rs_data), .rt_data(rt_data), .v0_data(v0_data),
      .pc(pc_s), .pc_plus4(pc_plus4_s), .halted(halted_s),
      .cycle_cnt(cycle_cnt_s), .jump_cnt(jump_cnt_s),
      .branch_cnt(branch_cnt_s), .taken_cnt(taken_cnt_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sat7(input longint v);
      return (v > 7) ? 32'd7 : 32'(v);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ":pc"},       pc,        m_pc);
      chk({tag, ":pc_plus4"}, pc_plus4,  m_pc + 32'd4);
      chk({tag, ":halted"},   {31'd0, halted}, {31'd0, m_halt});
      chk({tag, ":cycle"},    cycle_cnt,  32'(m_cyc));
      chk({tag, ":jump"},     jump_cnt,   32'(m_jmp));
      chk({tag, ":branch"},   branch_cnt, 32'(m_br));
      chk({tag, ":taken"},    taken_cnt,  32'(m_tk));
      chk({tag, ":s_cycle"},  {29'd0, cycle_cnt_s},  sat7(m_cyc));
      chk({tag, ":s_jump"},   {29'd0, jump_cnt_s},   sat7(m_jmp));
      chk({tag, ":s_branch"}, {29'd0, branch_cnt_s}, sat7(m_br));
      chk({tag, ":s_taken"},  {29'd0, taken_cnt_s},  sat7(m_tk));
   endtask

   task automatic mreset();
      m_pc = 32'h0; m_halt = 0;
      m_cyc = 0; m_jmp = 0; m_br = 0; m_tk = 0;
   endtask

   // Model of one clock edge, computed from the currently driven inputs.
   task automatic mstep();
      logic [31:0] p4;
      bit taken;
      int off;
      p4 = m_pc + 32'd4;
      taken = (beq && rs_data == rt_data) || (bne && rs_data != rt_data) ||
              (blez && $signed(rs_data) <= 0);
      if (m_halt) begin
         if (go) begin
            m_halt = 0;
            m_pc = p4;
         end
      end else begin
         m_cyc++;
         if (!stall) begin
            if (syscall && v0_data == 32'd10) begin
               m_halt = 1;
            end else if (jr) begin
               m_pc = rs_data;
            end else if (jmp || jal) begin
               m_pc = {p4[31:28], target26, 2'b00};
            end else if (taken) begin
               off = $signed(imm16);
               m_pc = p4 + 32'(off * 4);
            end else begin
               m_pc = p4;
            end
            if (jr || jmp || jal) m_jmp++;
            if (beq || bne || blez) m_br++;
            if (taken) m_tk++;
         end
      end
   endtask

   task automatic clr();
      stall = 0; go = 0; beq = 0; bne = 0; blez = 0; jmp = 0; jal = 0; jr = 0;
      syscall = 0; imm16 = 16'h0; target26 = 26'h0;
      rs_data = 32'h0; rt_data = 32'h0; v0_data = 32'h0;
   endtask

   task automatic tick(input string tag);
      mstep();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_jr(input logic [31:0] tgt);
      clr(); jr = 1; rs_data = tgt;
      tick("jr");
      clr();
   endtask

   initial begin
      clr();
      rst = 1;
      mreset();
      #3;
      check_all("reset");
      @(negedge clk);
      rst = 0;

      // Async reset from pc=0x40, then sequential fetch
      do_jr(32'h40);
      chk("pc_at_40", pc, 32'h40);
      rst = 1;
      #1;
      mreset();
      check_all("async_rst");
      chk("async_rst_pc", pc, 32'h0);
      #2;
      rst = 0;
      repeat (4) tick("seq");
      chk("seq_pc", pc, 32'h10);
      chk("seq_cycle", cycle_cnt, 32'd4);

      // beq taken backwards, then not taken
      do_jr(32'h100);
      beq = 1; rs_data = 32'd5; rt_data = 32'd5; imm16 = 16'hFFFE;
      tick("beq_t");
      chk("beq_taken_pc", pc, 32'hFC);
      do_jr(32'h100);
      beq = 1; rs_data = 32'd5; rt_data = 32'd6; imm16 = 16'hFFFE;
      tick("beq_nt");
      chk("beq_not_taken_pc", pc, 32'h104);

      // jal then jr back to the link address
      do_jr(32'h3000_0010);
      jal = 1; target26 = 26'h000_0040;
      chk("jal_link", pc_plus4, 32'h3000_0014);
      tick("jal");
      chk("jal_pc", pc, 32'h3000_0100);
      do_jr(32'h3000_0014);
      chk("jr_pc", pc, 32'h3000_0014);

      // blez boundaries
      clr(); blez = 1; imm16 = 16'h0010;
      rs_data = 32'h0;         tick("blez_0");
      rs_data = 32'h8000_0000; tick("blez_min");
      rs_data = 32'h1;         tick("blez_1");

      // Halting syscall, ignored inputs while halted, go resume
      do_jr(32'h20);
      syscall = 1; v0_data = 32'd10;
      tick("sys_halt");
      chk("sys_halted", {31'd0, halted}, 32'd1);
      clr(); jmp = 1; jr = 1; rs_data = 32'h5555; beq = 1; target26 = 26'h3FF;
      repeat (5) tick("halt_hold");
      chk("halt_pc", pc, 32'h20);
      clr(); go = 1;
      tick("go");
      chk("go_pc", pc, 32'h24);
      clr(); syscall = 1; v0_data = 32'd1;
      tick("sys_noop");
      chk("sys_noop_pc", pc, 32'h28);

      // Halting syscall held off by stall
      clr(); syscall = 1; v0_data = 32'd10; stall = 1;
      tick("sys_stall");
      chk("sys_stall_run", {31'd0, halted}, 32'd0);
      stall = 0;
      tick("sys_unstall");
      clr(); go = 1;
      tick("go2");

      // Stalled jump, then release; then reset mid-stall
      clr(); jmp = 1; target26 = 26'h012_3456; stall = 1;
      repeat (3) tick("stall_j");
      stall = 0;
      tick("stall_rel");
      stall = 1;
      tick("stall_again");
      rst = 1;
      #1;
      mreset();
      check_all("rst_stall");
      #2;
      rst = 0;

      // PC wrap
      do_jr(32'hFFFF_FFFC);
      tick("wrap");
      chk("wrap_pc", pc, 32'h0);

      // Random cycles
      for (int n = 0; n < 800; n++) begin
         int sel;
         clr();
         sel = $urandom_range(0, 9);
         case (sel)
            0: beq = 1;
            1: bne = 1;
            2: blez = 1;
            3: jmp = 1;
            4: jal = 1;
            5: jr = 1;
            6: syscall = 1;
            default: ;
         endcase
         if ($urandom_range(0, 15) == 0) begin
            {beq, bne, blez, jmp, jal, jr, syscall} = 7'($urandom);
         end
         stall = ($urandom_range(0, 4) == 0);
         go = ($urandom_range(0, 2) == 0);
         imm16 = 16'($urandom);
         target26 = 26'($urandom);
         rt_data = $urandom;
         case ($urandom_range(0, 3))
            0: rs_data = rt_data;
            1: rs_data = 32'h0;
            2: rs_data = 32'h8000_0000 | $urandom;
            default: rs_data = $urandom;
         endcase
         v0_data = $urandom_range(0, 1) ? 32'd10 : $urandom_range(0, 20);
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Single-cycle MIPS fetch-side sequencer. It sits downstream of the instruction decoder and consumes the decoded flow-control signals (beq, bne, blez, jmp, jal, jr, syscall).
- Holds the program counter, computes the next PC, and runs a RUN/HALT machine that stops the core on an exit syscall.
- Keeps performance counters (cycles, jumps, conditional branches, taken branches) for the board display.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_CODE, 32'd10, $v0 value that makes syscall halt the core
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  hold PC this cycle (memory wait); counters except cycle_cnt frozen
go  input  1  resume from HALT (single-cycle pulse, level also accepted)
beq  input  1  decoded beq
bne  input  1  decoded bne
blez  input  1  decoded blez
jmp  input  1  decoded j
jal  input  1  decoded jal
jr  input  1  decoded jr
syscall  input  1  decoded syscall
imm16  input  16  instruction[15:0]
target26  input  26  instruction[25:0]
rs_data  input  32  register-file read port 1
rt_data  input  32  register-file read port 2
v0_data  input  32  current $v0 value
pc  output  32  current PC (instruction fetch address)
pc_plus4  output  32  pc+4, also jal link value (combinational from pc)
halted  output  1  1 while in HALT state
cycle_cnt  output  CNT_W  cycles spent in RUN (stalled or not)
jump_cnt  output  CNT_W  retired j/jal/jr
branch_cnt  output  CNT_W  retired beq/bne/blez
taken_cnt  output  CNT_W  retired conditional branches that were taken

Behaviour:
- Reset, asynchronous on rst high: pc=RESET_PC, state=RUN, halted=0, all counters 0. Reset mid-operation aborts any pending redirect and takes effect immediately.
- States:
  - RUN: halted=0.
  - HALT: halted=1.
- Retire condition: an instruction retires in a cycle where state=RUN and stall=0. PC and event counters update only on retire.
- Branch condition:
  - beq: taken = (rs_data==rt_data).
  - bne: taken = (rs_data!=rt_data).
  - blez: taken = signed(rs_data)<=0.
- Targets:
  - br_tgt = pc_plus4 + (sign_extend(imm16)<<2), computed mod 2^32.
  - j_tgt = {pc_plus4[31:28], target26, 2'b00}.
  - jr target = rs_data, used unaligned as-is.
- Next-PC priority on retire, decoder guarantees one-hot but priority is fixed:
  1. syscall with v0_data==HALT_CODE: pc unchanged, state->HALT.
  2. jr: rs_data.
  3. jmp or jal: j_tgt.
  4. taken conditional branch: br_tgt.
  5. otherwise: pc_plus4. This includes a syscall with any other v0 value, which is a no-op here.
- No delay slot; the redirect applies on the next edge (latency 1 cycle).
- stall=1 in RUN: pc holds, no event counter change, cycle_cnt still increments. A halting syscall under stall does not halt until the stall clears.
- HALT:
  - pc holds; all control inputs ignored; counters frozen, including cycle_cnt.
  - go=1 -> RUN on the next edge, with pc <= pc+4 so execution proceeds past the syscall. Counters do not count that edge.
  - go in RUN is ignored.
- Counters:
  - jump_cnt +1 on retiring jr/jmp/jal.
  - branch_cnt +1 on retiring beq/bne/blez.
  - taken_cnt +1 if that branch is taken.
  - All counters saturate at 2^CNT_W-1, with no wrap.
- PC arithmetic wraps at 2^32: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000.

Test Plan:
- Reset at pc=0x40, then release; four plain cycles -> pc 0x0,0x4,0x8,0xC; cycle_cnt=4; other counters 0.
- pc=0x100, beq with rs=rt=5, imm16=0xFFFE -> next pc=0x100+4-8=0xFC; branch_cnt=1, taken_cnt=1. Repeat with rt=6 -> pc=0x104, taken_cnt unchanged.
- pc=0x3000_0010, jal target26=0x000_0040 -> pc=0x3000_0100, pc_plus4 before edge=0x3000_0014, jump_cnt=1. Then jr with rs_data=0x3000_0014 -> pc=0x3000_0014.
- blez boundaries:
  - rs_data=0 -> taken.
  - rs_data=0x8000_0000 -> taken.
  - rs_data=1 -> not taken.
  - Check taken_cnt=2 and branch_cnt=3.
- syscall:
  - v0=10 at pc=0x20 -> halted=1 next cycle; pc stays 0x20 for 5 cycles with counters frozen.
  - go pulse -> halted=0, pc=0x24.
  - syscall with v0=1 -> pc advances by 4, stays RUN.
- stall=1 for 3 cycles with jmp asserted -> pc holds and cycle_cnt +3, jump_cnt +0. Release stall -> pc=j_tgt, jump_cnt +1. Assert rst mid-stall -> pc=RESET_PC immediately, without waiting for a clock edge.
